// File: rtl/pe_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : pe_accumulator
// Summary  : Processing-element tile accumulator. Sums product beats into a
//            saturating/wrapping accumulator and hands the tile result
//            downstream over a valid/ready channel.
// Revision : 1.0
// ============================================================================
module pe_accumulator #(
  parameter int WIDTH_MUL = 32,
  parameter int WIDTH_ACC = 40,
  parameter int CNT_W     = 8,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_MUL-1:0] in_prod,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_acc,
  output logic [CNT_W-1:0]     out_cnt,
  output logic                 out_ovf
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_acc  = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;

  localparam logic [WIDTH_ACC-1:0] c_acc_ones = {WIDTH_ACC{1'b1}};
  localparam logic [WIDTH_ACC-1:0] c_acc_smax = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] c_acc_smin = {1'b1, {(WIDTH_ACC-1){1'b0}}};
  localparam logic [CNT_W-1:0]     c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     c_cnt_one  = CNT_W'(1);

  logic [1:0]           state_q, state_d;
  logic                 alive_q;
  logic [WIDTH_ACC-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH_ACC-1:0] prod_ext;
  logic [WIDTH_ACC:0]   sum_full;
  logic [WIDTH_ACC-1:0] sum;
  logic                 ovf_unsigned;
  logic                 ovf_signed;
  logic                 add_ovf;
  logic [WIDTH_ACC-1:0] sat_val;
  logic                 accept;

  generate
    if (WIDTH_ACC == WIDTH_MUL) begin : g_ext_same
      assign prod_ext = in_prod;
    end else begin : g_ext_wide
      logic pad;
      assign pad      = (SIGNED != 0) ? in_prod[WIDTH_MUL-1] : 1'b0;
      assign prod_ext = {{(WIDTH_ACC-WIDTH_MUL){pad}}, in_prod};
    end
  endgenerate

  assign accept       = in_valid & in_ready;
  assign sum_full     = {1'b0, acc_q} + {1'b0, prod_ext};
  assign sum          = sum_full[WIDTH_ACC-1:0];
  assign ovf_unsigned = sum_full[WIDTH_ACC];
  assign ovf_signed   = (acc_q[WIDTH_ACC-1] == prod_ext[WIDTH_ACC-1]) &&
                        (sum[WIDTH_ACC-1] != acc_q[WIDTH_ACC-1]);
  assign add_ovf      = (SIGNED != 0) ? ovf_signed : ovf_unsigned;
  // Signed clamp direction follows the operand sign: both operands agree on overflow.
  assign sat_val      = (SIGNED == 0)            ? c_acc_ones :
                        prod_ext[WIDTH_ACC-1]    ? c_acc_smin : c_acc_smax;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_idle;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle, c_acc: begin
        if (accept) state_d = in_last ? c_hold : c_acc;
      end
      c_hold: begin
        if (out_ready) state_d = c_idle;
      end
      default: state_d = c_idle;
    endcase
  end

  // FSM outputs; alive_q keeps in_ready low while reset is held
  always_comb begin
    in_ready  = alive_q && (state_q != c_hold);
    out_valid = (state_q == c_hold);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      if (state_q == c_idle) begin
        acc_d = prod_ext;
        cnt_d = c_cnt_one;
        ovf_d = 1'b0;
      end else begin
        acc_d = ((SATURATE != 0) && add_ovf) ? sat_val : sum;
        ovf_d = ovf_q | add_ovf;
        cnt_d = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_acc = acc_q;
  assign out_cnt = cnt_q;
  assign out_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_accumulator
// Summary  : Scoreboard bench driving six parameterisations of pe_accumulator
//            from one shared beat stream against a range-based sum model.
// Revision : 1.0
// ============================================================================
module tb_pe_accumulator;

  localparam int         N_INST = 6;
  localparam logic [5:0] C_SGN  = 6'b110010;
  localparam logic [5:0] C_SAT  = 6'b010111;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_last, out_ready, rnd_or;
  logic [31:0] in_prod;

  logic [N_INST-1:0] rdy_all, val_all, ovf_all;
  logic [63:0]       acc_all [N_INST];
  int                cnt_all [N_INST];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] acc;
    int          cnt;
    logic        ovf;
  } res_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam int WM = (g <= 1) ? 32 : 8;
    localparam int WA = (g <= 1) ? 40 : ((g == 4) ? 10 : 8);
    localparam int CW = (g == 4) ? 2 : ((g == 5) ? 4 : 8);
    localparam bit SG = C_SGN[g];
    localparam bit ST = C_SAT[g];
    localparam longint MODA = 64'sd1 <<< WA;
    localparam longint MODM = 64'sd1 <<< WM;
    localparam longint LO   = SG ? -(64'sd1 <<< (WA-1)) : 64'sd0;
    localparam longint HI   = SG ? (64'sd1 <<< (WA-1)) - 1 : MODA - 1;
    localparam logic [63:0] MASK = (64'd1 << WA) - 64'd1;
    localparam int CMAX = (1 << CW) - 1;

    logic          rdy, vld, ovf;
    logic [WA-1:0] acc;
    logic [CW-1:0] cnt;

    pe_accumulator #(
      .WIDTH_MUL(WM), .WIDTH_ACC(WA), .CNT_W(CW),
      .SIGNED(int'(SG)), .SATURATE(int'(ST))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(rdy), .in_prod(in_prod[WM-1:0]), .in_last(in_last),
      .out_valid(vld), .out_ready(out_ready),
      .out_acc(acc), .out_cnt(cnt), .out_ovf(ovf)
    );

    assign rdy_all[g] = rdy;
    assign val_all[g] = vld;
    assign ovf_all[g] = ovf;
    assign acc_all[g] = 64'(acc);
    assign cnt_all[g] = int'(cnt);

    res_t   q[$];
    bit     alive = 1'b0;
    bit     hold  = 1'b0;
    bit     open  = 1'b0;
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 1'b0;

    // Reference: true arithmetic sum clamped or folded back into the accumulator range.
    always begin : p_model
      logic        s_rst, s_v, s_l, s_or;
      logic [31:0] s_p;
      longint      val, t;
      res_t        r;
      @(negedge clk);
      #3;
      s_rst = rst_n; s_v = in_valid; s_l = in_last; s_or = out_ready; s_p = in_prod;
      if (!s_rst) begin
        alive = 0; hold = 0; open = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
        q.delete();
      end
      chk($sformatf("in_ready[%0d]", g), 64'(rdy), 64'(alive && !hold));
      @(posedge clk);
      if (s_rst) begin
        if (hold) begin
          if (s_or) hold = 0;
        end else if (alive && s_v) begin
          val = longint'(s_p[WM-1:0]);
          if (SG && s_p[WM-1]) val = val - MODM;
          if (!open) begin
            m_acc = val; m_cnt = 1; m_ovf = 0; open = 1;
          end else begin
            t = m_acc + val;
            if (t > HI) begin
              m_ovf = 1; m_acc = ST ? HI : t - MODA;
            end else if (t < LO) begin
              m_ovf = 1; m_acc = ST ? LO : t + MODA;
            end else begin
              m_acc = t;
            end
            if (m_cnt < CMAX) m_cnt++;
          end
          if (s_l) begin
            r.acc = 64'(m_acc) & MASK;
            r.cnt = m_cnt;
            r.ovf = m_ovf;
            q.push_back(r);
            open = 0;
            hold = 1;
          end
        end
        alive = 1;
      end
    end

    always begin : p_mon
      @(negedge clk);
      #4;
      chk($sformatf("out_valid[%0d]", g), 64'(vld), 64'(hold));
      if (vld) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL result[%0d]: got unexpected result acc %0h, expected none at %0t", g, acc, $time);
        end else begin
          chk($sformatf("out_acc[%0d]", g), 64'(acc), q[0].acc);
          chk($sformatf("out_cnt[%0d]", g), 64'(cnt), 64'(q[0].cnt));
          chk($sformatf("out_ovf[%0d]", g), 64'(ovf), 64'(q[0].ovf));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step_or();
    if (rnd_or) out_ready = (($urandom % 3) != 0);
  endtask

  // Present one beat and hold it until accepted; returns on the following negedge.
  task automatic send(input logic [31:0] p, input logic l);
    int tries = 0;
    bit done = 0;
    in_valid = 1'b1; in_prod = p; in_last = l;
    while (!done) begin
      #3;
      if (rdy_all[0]) done = 1;
      @(negedge clk);
      step_or();
      tries++;
      if (!done && tries > 50) begin
        n_vec++; n_err++;
        $display("FAIL send timeout: got no in_ready after %0d cycles, expected acceptance", tries);
        done = 1;
      end
    end
  endtask

  task automatic res_chk(input int g, input logic [63:0] a, input int c, input logic o, input string tag);
    chk({tag, " valid"}, 64'(val_all[g]), 64'd1);
    chk({tag, " acc"}, acc_all[g], a);
    chk({tag, " cnt"}, 64'(cnt_all[g]), 64'(c));
    chk({tag, " ovf"}, 64'(ovf_all[g]), 64'(o));
  endtask

  function automatic logic [31:0] rprod();
    case ($urandom % 4)
      0:       return 32'($urandom % 16);
      1:       return $urandom;
      2:       return 32'hFFFF_FFFF - 32'($urandom % 16);
      default: return 32'h70 + 32'($urandom % 32);
    endcase
  endfunction

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
    out_ready = 1'b1; rnd_or = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("reset in_ready", 64'(rdy_all), 64'd0);
    chk("reset out_valid", 64'(val_all), 64'd0);
    chk("reset acc", acc_all[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("in_ready before first edge", 64'(rdy_all), 64'd0);
    @(negedge clk);

    send(32'd3, 1'b0); send(32'd5, 1'b0); send(32'd7, 1'b1);
    in_valid = 1'b0; in_last = 1'b0; #4;
    res_chk(0, 64'd15, 3, 1'b0, "tile357");
    @(negedge clk);

    send(32'hFFFF_FFFC, 1'b0); send(32'd10, 1'b1);
    in_valid = 1'b0; in_last = 1'b0; #4;
    res_chk(1, 64'd6, 2, 1'b0, "signed");
    @(negedge clk);

    send(32'd200, 1'b0); send(32'd100, 1'b1);
    in_valid = 1'b0; in_last = 1'b0; #4;
    res_chk(2, 64'd255, 2, 1'b1, "sat8");
    res_chk(3, 64'd44, 2, 1'b1, "wrap8");
    @(negedge clk);

    for (int i = 0; i < 5; i++) send(32'd1, (i == 4));
    in_valid = 1'b0; in_last = 1'b0; #4;
    res_chk(4, 64'd5, 3, 1'b0, "cntsat");
    @(negedge clk);

    out_ready = 1'b0;
    send(32'd9, 1'b1);
    in_prod = 32'd77;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("hold in_ready", 64'(rdy_all), 64'd0);
      chk("hold out_valid", 64'(val_all), 64'h3F);
      chk("hold acc", acc_all[0], 64'd9);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(32'd77, 1'b1);
    in_valid = 1'b0; in_last = 1'b0; #4;
    res_chk(0, 64'd77, 1, 1'b0, "after hold");
    @(negedge clk);

    send(32'd1, 1'b0); send(32'd2, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #4;
    chk("midreset out_valid", 64'(val_all), 64'd0);
    chk("midreset acc", acc_all[0], 64'd0);
    chk("midreset in_ready", 64'(rdy_all), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd1, 1'b0); send(32'd1, 1'b1);
    in_valid = 1'b0; in_last = 1'b0; #4;
    res_chk(0, 64'd2, 2, 1'b0, "post reset");
    @(negedge clk);

    rnd_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 4) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        step_or();
      end
      send(rprod(), (($urandom % 4) == 0));
    end
    in_valid = 1'b0; in_last = 1'b0;
    rnd_or = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
